freq_meter: RTL
===============

FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 100000000, gate window length in clk_100MHz_i cycles (>=2).
REQ-002 Parameter CNT_W, default 34, width of the edge count result.
REQ-003 clk_100MHz_i  input  1  the single clock; all flops on its rising edge.
REQ-004 rstn_i  input  1  reset, synchronous and active-low.
REQ-005 sig_i  input  1  measured signal, asynchronous to clk_100MHz_i, frequency < 50 MHz.
REQ-006 en_i  input  1  level enable; high starts and repeats measurements.
REQ-007 ack_i  input  1  consumer acknowledge of a held result.
REQ-008 cnt_o  output  CNT_W  rising-edge count of sig_i in the last completed gate.
REQ-009 valid_o  output  1  cnt_o/ovf_o hold a new result awaiting ack_i.
REQ-010 ovf_o  output  1  result saturated at all-ones.
REQ-011 busy_o  output  1  high in states ARM and GATE.

Function
REQ-012 sig_i SHALL pass a 2-flop synchronizer then a delay flop; a rising edge is detected in the cycle where sync2=1 and delay=0.
REQ-013 FSM states IDLE, ARM, GATE, HOLD; encoding is free.
REQ-014 IDLE: en_i=1 -> ARM next cycle; otherwise stay.
REQ-015 ARM: lasts exactly 1 cycle; clears edge counter, ovf flag and gate counter; -> GATE.
REQ-016 GATE: lasts exactly GATE_CYCLES cycles; every detected edge in those cycles increments the edge counter, including the last cycle.
REQ-017 Edge counter saturates at 2^CNT_W-1; a further edge sets internal ovf flag, counter holds.
REQ-018 End of GATE: cnt_o <= edge counter, ovf_o <= ovf flag, valid_o <= 1 on the same edge; state -> HOLD.
REQ-019 en_i=0 in any GATE cycle: abort to IDLE next cycle; cnt_o, ovf_o, valid_o unchanged.
REQ-020 HOLD: valid_o, cnt_o, ovf_o stable until ack_i=1; no counting in HOLD.
REQ-021 HOLD with ack_i=1: valid_o <= 0; -> ARM if en_i=1, else IDLE.
REQ-022 ack_i outside HOLD SHALL be ignored.
REQ-023 Result latency: valid_o rises GATE_CYCLES+1 cycles after the ARM cycle.
REQ-024 Edges occurring in IDLE, ARM or HOLD SHALL NOT be counted.

Reset
REQ-025 rstn_i=0 sampled on a clock edge: state IDLE, cnt_o=0, valid_o=0, ovf_o=0, busy_o=0, all counters and synchronizer flops 0.
REQ-026 Reset mid-GATE or mid-HOLD SHALL discard the measurement; no valid_o pulse follows.
REQ-027 First ARM possible on the first edge after rstn_i returns high with en_i=1.

Configuration
REQ-028 Macro FREQ_METER_LOCK_GATE_EN: when defined, adds input locked_i (1 bit, PLL lock) and output err_o (1 bit).
REQ-029 With macro: locked_i=0 in any GATE cycle aborts to IDLE as REQ-019 and sets err_o=1; err_o clears in ARM and on reset; IDLE->ARM additionally requires locked_i=1.
REQ-030 Without macro: ports locked_i/err_o absent; behaviour exactly REQ-001..027.

Verification
REQ-031 GATE_CYCLES=100, sig_i period 4 clk, en_i=1 -> valid_o at ARM+101 cycles, cnt_o=25, ovf_o=0.
REQ-032 CNT_W=4, GATE_CYCLES=100, sig_i period 4 clk -> cnt_o=15, ovf_o=1.
REQ-033 Result held, ack_i low 50 cycles -> cnt_o/valid_o stable; ack_i pulse with en_i=1 -> valid_o=0, next result after further 101 cycles.
REQ-034 en_i dropped at GATE cycle 40 -> IDLE, valid_o stays 0, previous cnt_o retained.
REQ-035 rstn_i=0 one cycle mid-GATE -> all outputs 0 next cycle, no valid_o until a full new gate.
REQ-036 With FREQ_METER_LOCK_GATE_EN: locked_i=0 at GATE cycle 10 -> err_o=1, IDLE, no result; locked_i=1 -> ARM, err_o=0.

Source files
------------

// File: rtl/freq_meter.sv
// Gated edge counter: counts rising edges of an asynchronous signal over GATE_CYCLES clocks.
// Optional macro FREQ_METER_LOCK_GATE_EN adds PLL-lock gating (locked_i) and an error flag (err_o).

module freq_meter #(
   parameter int unsigned GATE_CYCLES = 100000000,
   parameter int unsigned CNT_W       = 34
) (
   input  logic             clk_100MHz_i,
   input  logic             rstn_i,
   input  logic             sig_i,
   input  logic             en_i,
   input  logic             ack_i,
`ifdef FREQ_METER_LOCK_GATE_EN
   input  logic             locked_i,
   output logic             err_o,
`endif
   output logic [CNT_W-1:0] cnt_o,
   output logic             valid_o,
   output logic             ovf_o,
   output logic             busy_o
);

   localparam int unsigned   GW        = $clog2(GATE_CYCLES);
   localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StArm  = 2'd1;
   localparam logic [1:0] StGate = 2'd2;
   localparam logic [1:0] StHold = 2'd3;

   logic [1:0]       state_q, state_d;
   logic             sync1_q, sync2_q, dly_q;
   logic             edge_det;
   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d, edge_cnt_nxt;
   logic             ovf_q, ovf_d, ovf_nxt;
   logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic             res_ovf_q, res_ovf_d;
   logic             lock_ok;

`ifdef FREQ_METER_LOCK_GATE_EN
   logic err_q;

   assign lock_ok = locked_i;
   assign err_o   = err_q;

   always_ff @(posedge clk_100MHz_i) begin
      if (!rstn_i) begin
         err_q <= 1'b0;
      end else if (state_q == StArm) begin
         err_q <= 1'b0;
      end else if (state_q == StGate && !locked_i) begin
         err_q <= 1'b1;
      end
   end
`else
   assign lock_ok = 1'b1;
`endif

   assign edge_det = sync2_q & ~dly_q;

   // Counter value including this cycle's edge, so the last gate cycle lands in the result.
   always_comb begin
      edge_cnt_nxt = edge_cnt_q;
      ovf_nxt      = ovf_q;
      if (edge_det) begin
         if (&edge_cnt_q) begin
            ovf_nxt = 1'b1;
         end else begin
            edge_cnt_nxt = edge_cnt_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      edge_cnt_d = edge_cnt_q;
      ovf_d      = ovf_q;
      gate_cnt_d = gate_cnt_q;
      cnt_d      = cnt_q;
      valid_d    = valid_q;
      res_ovf_d  = res_ovf_q;
      unique case (state_q)
         StIdle: begin
            if (en_i && lock_ok) begin
               state_d = StArm;
            end
         end
         StArm: begin
            edge_cnt_d = '0;
            ovf_d      = 1'b0;
            gate_cnt_d = '0;
            state_d    = StGate;
         end
         StGate: begin
            edge_cnt_d = edge_cnt_nxt;
            ovf_d      = ovf_nxt;
            gate_cnt_d = gate_cnt_q + GW'(1);
            // An abort wins even on the final gate cycle: no partial result is published.
            if (!en_i || !lock_ok) begin
               state_d = StIdle;
            end else if (gate_cnt_q == GATE_LAST) begin
               cnt_d     = edge_cnt_nxt;
               res_ovf_d = ovf_nxt;
               valid_d   = 1'b1;
               state_d   = StHold;
            end
         end
         StHold: begin
            if (ack_i) begin
               valid_d = 1'b0;
               state_d = en_i ? StArm : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_100MHz_i) begin
      if (!rstn_i) begin
         state_q    <= StIdle;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         dly_q      <= 1'b0;
         edge_cnt_q <= '0;
         ovf_q      <= 1'b0;
         gate_cnt_q <= '0;
         cnt_q      <= '0;
         valid_q    <= 1'b0;
         res_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync1_q    <= sig_i;
         sync2_q    <= sync1_q;
         dly_q      <= sync2_q;
         edge_cnt_q <= edge_cnt_d;
         ovf_q      <= ovf_d;
         gate_cnt_q <= gate_cnt_d;
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
         res_ovf_q  <= res_ovf_d;
      end
   end

   assign cnt_o   = cnt_q;
   assign valid_o = valid_q;
   assign ovf_o   = res_ovf_q;
   assign busy_o  = (state_q == StArm) || (state_q == StGate);

endmodule
